// File: rtl/crate_map_pkg.sv
// crate_map_pkg: shared definitions for the crate frame serializer.
//   - ROW_W / N_ROWS : frame geometry (38 rows of 38 bits)
//   - HDR_ROW_ID     : out_row value that marks the header word
//   - HDR_MARK       : fixed mark pattern carried in header bits [15:0]
//   - state_e        : serializer FSM states
//   - frame_hdr_t    : header bitfield layout
package crate_map_pkg;

  localparam int          ROW_W      = 38;
  localparam int          N_ROWS     = 38;
  localparam logic [5:0]  HDR_ROW_ID = 6'h3F;
  localparam logic [15:0] HDR_MARK   = 16'hAAAA;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    ROWS = 2'd2
  } state_e;

  typedef struct packed {
    logic        done;       // [37]    one-cycle done strobe
    logic [10:0] crate_tag;  // [36:26]
    logic [9:0]  fiber_id;   // [25:16]
    logic [15:0] mark;       // [15:0]
  } frame_hdr_t;

  // Done strobe of a header word.
  function automatic logic hdr_is_done(input frame_hdr_t h);
    return h.done;
  endfunction

endpackage

// File: rtl/row_find_next.sv
// row_find_next: priority search over a per-row nonzero mask.
//   mask_i  : bit r set when row r holds a nonzero value
//   start_i : first index allowed in the search (inclusive)
//   next_o  : lowest set index >= start_i (0 when none exists)
//   last_o  : no set bit lies above next_o, i.e. next_o is the final row to send
// Only used when the build defines ZERO_ROW_SKIP_EN.
module row_find_next
  import crate_map_pkg::*;
#(
  parameter int N_ROWS_P = crate_map_pkg::N_ROWS
) (
  input  logic [N_ROWS_P-1:0] mask_i,
  input  logic [5:0]          start_i,
  output logic [5:0]          next_o,
  output logic                last_o
);

  logic more_s;

  // Lowest qualifying index: scan downward so the lowest hit is written last.
  always_comb begin
    next_o = 6'd0;
    for (int i = N_ROWS_P - 1; i >= 0; i--) begin
      if (mask_i[i] && (6'(i) >= start_i)) begin
        next_o = 6'(i);
      end else begin
        next_o = next_o;
      end
    end
  end

  // Any nonzero row beyond the selected one means more rows follow.
  always_comb begin
    more_s = 1'b0;
    for (int i = 0; i < N_ROWS_P; i++) begin
      more_s = more_s | (mask_i[i] & (6'(i) > next_o));
    end
    last_o = ~more_s;
  end

endmodule

// File: rtl/crate_frame_serializer.sv
// crate_frame_serializer: captures one mapper frame (header + N_ROWS rows) in a
// single cycle and replays it as ROW_W-bit words under valid/ready.
// Optional build macro: ZERO_ROW_SKIP_EN (zero rows are not sent).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   hdr_in, rows_in   mapper header (bit ROW_W-1 = done strobe) and flattened rows
//   out_data/out_row  current word and its index (HDR_ROW_ID for the header)
//   out_valid/ready   stream handshake; out_sof/out_eof frame delimiters
//   busy              a frame is held and not fully sent
//   drop_cnt          saturating count of frames lost to overrun
module crate_frame_serializer
  import crate_map_pkg::*;
#(
  parameter int N_ROWS = crate_map_pkg::N_ROWS,
  parameter int ROW_W  = crate_map_pkg::ROW_W,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ROW_W-1:0]        hdr_in,
  input  logic [N_ROWS*ROW_W-1:0] rows_in,
  output logic [ROW_W-1:0]        out_data,
  output logic [5:0]              out_row,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sof,
  output logic                    out_eof,
  output logic                    busy,
  output logic [CNT_W-1:0]        drop_cnt
);

  state_e             state_q, state_d;
  logic [5:0]         ptr_q, ptr_d;
  logic [ROW_W-1:0]   rows_q [N_ROWS];
  logic [ROW_W-1:0]   data_q, data_d;
  logic [5:0]         row_q, row_d;
  logic               valid_q, valid_d;
  logic               sof_q, sof_d;
  logic               eof_q, eof_d;
  logic [CNT_W-1:0]   drop_q, drop_d;

  logic               trig_s, accept_s, free_s, capture_s, drop_s;
  logic [5:0]         start_s, next_idx_s;
  logic               last_s, hdr_eof_s;

  assign trig_s    = hdr_is_done(frame_hdr_t'(hdr_in));
  assign accept_s  = valid_q & out_ready;
  // The block is free in IDLE or when the final beat leaves this very cycle.
  assign free_s    = (state_q == IDLE) | (accept_s & eof_q);
  assign capture_s = trig_s & free_s;
  assign drop_s    = trig_s & ~free_s;
  // After the header the search starts at row 0, otherwise just past ptr.
  assign start_s   = (state_q == HDR) ? 6'd0 : (ptr_q + 6'd1);

`ifdef ZERO_ROW_SKIP_EN
  logic [N_ROWS-1:0] nz_in_s, nz_q;

  // Per-row nonzero flags of the incoming frame.
  always_comb begin
    nz_in_s = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      nz_in_s[r] = |rows_in[r*ROW_W +: ROW_W];
    end
  end

  // Nonzero mask travels with the captured frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nz_q <= '0;
    end else if (capture_s) begin
      nz_q <= nz_in_s;
    end else begin
      nz_q <= nz_q;
    end
  end

  row_find_next #(.N_ROWS_P(N_ROWS)) u_row_find_next (
    .mask_i  (nz_q),
    .start_i (start_s),
    .next_o  (next_idx_s),
    .last_o  (last_s)
  );

  // An all-zero frame is a lone header that also closes the frame.
  assign hdr_eof_s = ~|nz_in_s;
`else
  assign next_idx_s = start_s;
  assign last_s     = (start_s == 6'(N_ROWS - 1));
  assign hdr_eof_s  = 1'b0;
`endif

  // Next state, pointer and registered output word.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    row_d   = row_q;
    valid_d = valid_q;
    sof_d   = sof_q;
    eof_d   = eof_q;
    case (state_q)
      IDLE, HDR, ROWS: begin
        if (capture_s) begin
          state_d = HDR;
          ptr_d   = 6'd0;
          data_d  = hdr_in;
          row_d   = HDR_ROW_ID;
          valid_d = 1'b1;
          sof_d   = 1'b1;
          eof_d   = hdr_eof_s;
        end else if (accept_s && eof_q) begin
          state_d = IDLE;
          ptr_d   = 6'd0;
          data_d  = '0;
          row_d   = 6'd0;
          valid_d = 1'b0;
          sof_d   = 1'b0;
          eof_d   = 1'b0;
        end else if (accept_s) begin
          state_d = ROWS;
          ptr_d   = next_idx_s;
          data_d  = rows_q[next_idx_s];
          row_d   = next_idx_s;
          valid_d = 1'b1;
          sof_d   = 1'b0;
          eof_d   = last_s;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = 6'd0;
        data_d  = '0;
        row_d   = 6'd0;
        valid_d = 1'b0;
        sof_d   = 1'b0;
        eof_d   = 1'b0;
      end
    endcase
  end

  // Saturating overrun counter.
  always_comb begin
    if (drop_s && (drop_q != {CNT_W{1'b1}})) begin
      drop_d = drop_q + CNT_W'(1);
    end else begin
      drop_d = drop_q;
    end
  end

  // State, pointer, output and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 6'd0;
      data_q  <= '0;
      row_q   <= 6'd0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      drop_q  <= drop_d;
    end
  end

  // Row buffer loads the whole frame on capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N_ROWS; r++) rows_q[r] <= '0;
    end else if (capture_s) begin
      for (int r = 0; r < N_ROWS; r++) rows_q[r] <= rows_in[r*ROW_W +: ROW_W];
    end else begin
      for (int r = 0; r < N_ROWS; r++) rows_q[r] <= rows_q[r];
    end
  end

  assign out_data  = data_q;
  assign out_row   = row_q;
  assign out_valid = valid_q;
  assign out_sof   = sof_q;
  assign out_eof   = eof_q;
  assign busy      = (state_q != IDLE);
  assign drop_cnt  = drop_q;

endmodule

// File: doc/crate_frame_serializer.md
# crate_frame_serializer

- Captures one completed hit-map frame from a crate mapping block in a single cycle: a 38-bit header plus 38 rows of 38 bits.
- Replays the frame as a stream of 38-bit words under a valid/ready handshake toward the event-builder link.
- Sits directly after a crate mapper. It decouples the mapper's one-cycle done strobe from downstream backpressure and counts frames lost to overrun.

## Interface
Parameters:
- N_ROWS, 38: rows per frame.
- ROW_W, 38: bits per row and per output word.
- CNT_W, 8: width of the drop counter.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- hdr_in  in  ROW_W  mapper header; bit 37 high marks the one-cycle done strobe.
- rows_in  in  N_ROWS*ROW_W  mapper rows, flattened; row r occupies bits [r*ROW_W +: ROW_W].
- out_data  out  ROW_W  current word: the header or one row.
- out_row  out  6  index of the current word: 6'h3F for the header, r for row r.
- out_valid  out  1  out_data, out_row, out_sof and out_eof are valid.
- out_ready  in  1  downstream accepts the word this cycle.
- out_sof  out  1  high with the header word.
- out_eof  out  1  high with the last word of the frame.
- busy  out  1  a frame is held and not yet fully sent.
- drop_cnt  out  CNT_W  saturating count of frames lost to overrun.

## Operation
- Capture trigger: hdr_in[37]==1 on a cycle where the block is free.
  - Free means state IDLE, or the eof beat is accepted in that same cycle.
  - On capture, the header and all rows are registered into the frame buffer.
- Overrun: a trigger while not free drops the frame.
  - The held frame is unaffected.
  - drop_cnt increments and sticks at 2^CNT_W-1.
- State machine:
  - IDLE to HDR on capture.
  - HDR presents the header with out_sof=1. On accept, go to ROWS with ptr set to the first row to send.
  - ROWS presents row[ptr]. On accept, ptr advances to the next row to send.
  - On accepting the last row: go to HDR if a same-cycle capture occurred, else to IDLE.
- out_data, out_row, out_sof and out_eof hold stable while out_valid && !out_ready.
- A transfer happens only when out_valid && out_ready.
- busy = (state != IDLE).
- ptr is 6 bits. Rows are sent in ascending order 0..N_ROWS-1, with no wrap.

## Timing
- Reset values: out_data=0, out_row=0, out_valid=0, out_sof=0, out_eof=0, busy=0, drop_cnt=0; state IDLE; buffer cleared.
- Latency: trigger at cycle T gives the header on out_valid at T+1.
- Throughput: one word per cycle while out_ready=1, so a full frame takes N_ROWS+1 = 39 beats.
- Back-to-back: eof accepted at cycle T together with a trigger at T gives the new header at T+1, with no bubble.
- out_valid is registered. out_ready affects only the next-cycle state and has no combinational path to out_valid.
- rst asserted mid-frame immediately returns every output to its reset value. The partial frame is discarded and is not counted as a drop.

## Configuration
- Macro ZERO_ROW_SKIP_EN.
- Defined:
  - Rows equal to zero are not sent. ptr jumps to the next nonzero row with a combinational priority search over a per-row nonzero mask captured with the frame.
  - out_eof is set on the last nonzero row.
  - If every row is zero, the header is the only word and carries out_sof=1 and out_eof=1.
- Not defined: all N_ROWS rows are always sent, and out_eof is set on row N_ROWS-1.

## Structure
- Shared package (crate_map_pkg) holds:
  - ROW_W, N_ROWS, HDR_ROW_ID=6'h3F, HDR_MARK=16'hAAAA;
  - the state enum {IDLE, HDR, ROWS};
  - a frame-header bitfield typedef: [15:0] mark, [25:16] fiber id, [36:26] crate tag, [37] done.
- One sub-module, row_find_next: given the nonzero mask and ptr, it returns the next nonzero index and a last flag. It is instantiated only under ZERO_ROW_SKIP_EN.

## Test plan
- Basic frame, skip off:
  - Stimulus: trigger with hdr_in=38'h20_0200_AAAA, row r = r+1, out_ready=1.
  - Response: 39 beats. Header has out_row=3F and out_sof=1. Rows carry out_row 0..37 with data 1..38. out_eof only on row 37.
- Backpressure:
  - Stimulus: out_ready low for 3 cycles on row 5.
  - Response: out_data=6 and out_row=5 held stable all 3 cycles. Row 6 follows only after out_ready returns high.
- Overrun:
  - Stimulus: second trigger at beat 10 of a frame.
  - Response: the current frame completes unchanged and drop_cnt=1.
  - Stimulus: 300 such overruns.
  - Response: drop_cnt=255.
- Back-to-back:
  - Stimulus: trigger in the same cycle the eof is accepted.
  - Response: the new header appears on the next cycle and drop_cnt is unchanged.
- Skip on:
  - Stimulus: only rows 21 and 30 nonzero.
  - Response: header, then row 21, then row 30 with out_eof=1.
  - Stimulus: all rows zero.
  - Response: a single header beat with out_sof=1 and out_eof=1.
- Reset mid-frame:
  - Stimulus: assert rst at beat 20.
  - Response: out_valid=0 in the same cycle. After release the block is IDLE and a new trigger produces a clean frame.
